// File: rtl/line_buf_pkg.sv
// -----------------------------------------------------------------------------
// line_buf_pkg
// Shared constants, types and helpers for the line-buffer bank controller.
//   NUM_BUFS          : number of line buffers in the bank (fixed at 4)
//   pixel_width()     : pixel width derived from integer + fractional bits
//   lbc_state_e       : controller FSM states {IDLE, READ}
//   inc_mod4()        : wrap-around increment of a buffer selector
//   buf_slot()        : buffer index that is <offset> places after <base>
//   window_mask()     : read-enable mask for the three buffers of a window
// -----------------------------------------------------------------------------
package line_buf_pkg;

    localparam int unsigned NUM_BUFS             = 4;
    localparam int unsigned DEF_INTEGER_BITS     = 8;
    localparam int unsigned DEF_FIXED_POINT_BITS = 4;

    typedef logic [1:0] buf_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } lbc_state_e;

    function automatic int unsigned pixel_width(input int unsigned int_bits,
                                                input int unsigned frac_bits);
        return int_bits + frac_bits;
    endfunction

    function automatic buf_sel_t inc_mod4(input buf_sel_t sel);
        return sel + 2'd1;
    endfunction

    // Two-bit arithmetic gives the modulo-4 wrap for free.
    function automatic buf_sel_t buf_slot(input buf_sel_t    base,
                                          input int unsigned offset);
        return base + buf_sel_t'(offset);
    endfunction

    function automatic logic [NUM_BUFS-1:0] window_mask(input buf_sel_t base);
        logic [NUM_BUFS-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            mask[buf_slot(base, i)] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/lbc_window_mux.sv
// -----------------------------------------------------------------------------
// lbc_window_mux
// Combinational selector that gathers the 3-pixel outputs of the three buffers
// starting at i_rd_sel and stacks them into a 3x3 window, oldest line in MSBs.
//   i_rd_sel   : oldest buffer of the current window
//   i_buf_data : all four buffers' 3-pixel outputs, buffer k at slice k
//   o_window   : {buf[rd_sel], buf[rd_sel+1], buf[rd_sel+2]}
// -----------------------------------------------------------------------------
module lbc_window_mux
    import line_buf_pkg::*;
#(
    parameter int unsigned PW = 12
) (
    input  logic [1:0]        i_rd_sel,
    input  logic [4*3*PW-1:0] i_buf_data,
    output logic [9*PW-1:0]   o_window
);

    localparam int unsigned SW = 3 * PW;

    for (genvar i = 0; i < 3; i++) begin : g_row
        buf_sel_t slot;
        assign slot = buf_slot(i_rd_sel, i);
        assign o_window[(2-i)*SW +: SW] = i_buf_data[slot*SW +: SW];
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// line_buffer_ctrl
// Sequencing controller for a four-line-buffer bank. Pixels are written into
// the buffers round-robin one line at a time; once three lines are resident the
// three oldest are read together as a 3x3 window stream, after which the read
// triple rotates by one buffer.
//
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_pixel_data     : incoming pixel (PW bits)
//   i_pixel_valid    : pixel present this cycle
//   o_pixel_ready    : pixel accepted when valid && ready
//   o_wr_data        : pixel to the buffers (pass-through)
//   o_wr_valid       : one-hot write strobe to the current write buffer
//   o_rd_en          : read-advance strobes, three bits set while reading
//   i_buf_data       : buffer k's 3-pixel output at slice k
//   o_window         : registered 3x3 window, oldest line in MSBs
//   o_window_valid   : o_window holds a new window
//   o_intr           : one-cycle pulse after a line of windows is finished
//   o_drop_cnt       : (LBC_DROP_CNT_EN only) saturating count of dropped pixels
//
// Optional feature macro: LBC_DROP_CNT_EN
// -----------------------------------------------------------------------------
module line_buffer_ctrl
    import line_buf_pkg::*;
#(
    parameter  int unsigned INTEGER_BITS     = DEF_INTEGER_BITS,
    parameter  int unsigned FIXED_POINT_BITS = DEF_FIXED_POINT_BITS,
    parameter  int unsigned LINE_WIDTH       = 512,
    localparam int unsigned PW               = INTEGER_BITS + FIXED_POINT_BITS
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [PW-1:0]              i_pixel_data,
    input  logic                       i_pixel_valid,
    output logic                       o_pixel_ready,
    output logic [PW-1:0]              o_wr_data,
    output logic [NUM_BUFS-1:0]        o_wr_valid,
    output logic [NUM_BUFS-1:0]        o_rd_en,
    input  logic [NUM_BUFS*3*PW-1:0]   i_buf_data,
    output logic [9*PW-1:0]            o_window,
    output logic                       o_window_valid,
    output logic                       o_intr
`ifdef LBC_DROP_CNT_EN
    ,
    output logic [15:0]                o_drop_cnt
`endif
);

    // Line position counters; occupancy needs two more bits to reach 4 lines.
    localparam int unsigned CW = $clog2(LINE_WIDTH) + 1;
    localparam int unsigned TW = $clog2(LINE_WIDTH) + 3;

    localparam logic [CW-1:0] LAST_IDX = CW'(LINE_WIDTH - 1);
    localparam logic [TW-1:0] FULL_LVL = TW'(NUM_BUFS * LINE_WIDTH);
    localparam logic [TW-1:0] READ_LVL = TW'(3 * LINE_WIDTH);

    logic [CW-1:0]   wr_cnt_q,       wr_cnt_d;
    buf_sel_t        wr_sel_q,       wr_sel_d;
    logic [CW-1:0]   rd_cnt_q,       rd_cnt_d;
    buf_sel_t        rd_sel_q,       rd_sel_d;
    logic [TW-1:0]   total_cnt_q,    total_cnt_d;
    lbc_state_e      state_q,        state_d;
    logic [9*PW-1:0] window_q,       window_d;
    logic            window_valid_q, window_valid_d;
    logic            intr_q,         intr_d;

    logic            pixel_ready;
    logic            wr_fire;
    logic            rd_fire;
    logic [9*PW-1:0] mux_window;

    lbc_window_mux #(
        .PW (PW)
    ) u_window_mux (
        .i_rd_sel   (rd_sel_q),
        .i_buf_data (i_buf_data),
        .o_window   (mux_window)
    );

    // Write side and occupancy
    always_comb begin
        pixel_ready = (total_cnt_q < FULL_LVL);
        wr_fire     = i_pixel_valid && pixel_ready;
        rd_fire     = (state_q == READ);

        wr_cnt_d    = wr_cnt_q;
        wr_sel_d    = wr_sel_q;
        total_cnt_d = total_cnt_q;

        if (wr_fire) begin
            if (wr_cnt_q == LAST_IDX) begin
                wr_cnt_d = '0;
                wr_sel_d = inc_mod4(wr_sel_q);
            end else begin
                wr_cnt_d = wr_cnt_q + CW'(1);
            end
        end

        // Simultaneous write and read cancel out; bounds guard against wrap.
        unique case ({wr_fire, rd_fire})
            2'b10: if (total_cnt_q != FULL_LVL) total_cnt_d = total_cnt_q + TW'(1);
            2'b01: if (total_cnt_q != '0)       total_cnt_d = total_cnt_q - TW'(1);
            default: total_cnt_d = total_cnt_q;
        endcase
    end

    // Read FSM and window register inputs
    always_comb begin
        state_d        = state_q;
        rd_cnt_d       = rd_cnt_q;
        rd_sel_d       = rd_sel_q;
        intr_d         = 1'b0;
        window_d       = window_q;
        window_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (total_cnt_q >= READ_LVL) begin
                    state_d = READ;
                end
            end
            READ: begin
                window_d       = mux_window;
                window_valid_d = 1'b1;
                if (rd_cnt_q == LAST_IDX) begin
                    rd_cnt_d = '0;
                    rd_sel_d = inc_mod4(rd_sel_q);
                    state_d  = IDLE;
                    intr_d   = 1'b1;
                end else begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_cnt_q       <= '0;
            wr_sel_q       <= '0;
            rd_cnt_q       <= '0;
            rd_sel_q       <= '0;
            total_cnt_q    <= '0;
            state_q        <= IDLE;
            window_q       <= '0;
            window_valid_q <= 1'b0;
            intr_q         <= 1'b0;
        end else begin
            wr_cnt_q       <= wr_cnt_d;
            wr_sel_q       <= wr_sel_d;
            rd_cnt_q       <= rd_cnt_d;
            rd_sel_q       <= rd_sel_d;
            total_cnt_q    <= total_cnt_d;
            state_q        <= state_d;
            window_q       <= window_d;
            window_valid_q <= window_valid_d;
            intr_q         <= intr_d;
        end
    end

    assign o_pixel_ready  = pixel_ready;
    assign o_wr_data      = i_pixel_data;
    assign o_wr_valid     = wr_fire ? (NUM_BUFS'(1) << wr_sel_q) : '0;
    assign o_rd_en        = rd_fire ? window_mask(rd_sel_q) : '0;
    assign o_window       = window_q;
    assign o_window_valid = window_valid_q;
    assign o_intr         = intr_q;

`ifdef LBC_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (i_pixel_valid && !pixel_ready && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_buffer_ctrl
// Directed bench for line_buffer_ctrl with LINE_WIDTH=16. A behavioural model
// tracks total pixels written and total read cycles; everything else (write
// buffer, read triple, occupancy, window contents) is derived arithmetically
// from those two totals. Buffer k at read position n presents pixel values
// (j<<8) | (k*16+n) for its three taps j=0..2.
// -----------------------------------------------------------------------------
module tb_line_buffer_ctrl;

    localparam int unsigned LW = 16;
    localparam int unsigned PW = 12;
    localparam int unsigned SW = 3 * PW;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [PW-1:0]     i_pixel_data = '0;
    logic              i_pixel_valid = 1'b0;
    logic              o_pixel_ready;
    logic [PW-1:0]     o_wr_data;
    logic [3:0]        o_wr_valid;
    logic [3:0]        o_rd_en;
    logic [4*SW-1:0]   i_buf_data = '0;
    logic [9*PW-1:0]   o_window;
    logic              o_window_valid;
    logic              o_intr;
`ifdef LBC_DROP_CNT_EN
    logic [15:0]       o_drop_cnt;
`endif

    always #5 i_clk = ~i_clk;

    line_buffer_ctrl #(
        .INTEGER_BITS     (8),
        .FIXED_POINT_BITS (4),
        .LINE_WIDTH       (LW)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_pixel_data   (i_pixel_data),
        .i_pixel_valid  (i_pixel_valid),
        .o_pixel_ready  (o_pixel_ready),
        .o_wr_data      (o_wr_data),
        .o_wr_valid     (o_wr_valid),
        .o_rd_en        (o_rd_en),
        .i_buf_data     (i_buf_data),
        .o_window       (o_window),
        .o_window_valid (o_window_valid),
        .o_intr         (o_intr)
`ifdef LBC_DROP_CNT_EN
        ,
        .o_drop_cnt     (o_drop_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_wr = 0;       // pixels accepted since reset
    int              m_rd = 0;       // read cycles since reset
    int              m_drops = 0;
    bit              m_reading = 0;
    bit              m_intr = 0;
    bit              m_wv = 0;
    logic [9*PW-1:0] m_win = '0;

    function automatic logic [PW-1:0] pix(input int k, input int n, input int j);
        return PW'((j << 8) | (k * 16 + n));
    endfunction

    function automatic logic [4*SW-1:0] gen_buf(input int n);
        logic [4*SW-1:0] b;
        b = '0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 3; j++)
                b[k*SW + (2-j)*PW +: PW] = pix(k, n, j);
        return b;
    endfunction

    function automatic logic [9*PW-1:0] exp_window(input int s, input int n);
        logic [9*PW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(8 - (i*3 + j))*PW +: PW] = pix((s + i) % 4, n, j);
        return w;
    endfunction

    always @(posedge i_clk) begin
        int occ;
        if (i_rst) begin
            m_wr = 0; m_rd = 0; m_drops = 0;
            m_reading = 0; m_intr = 0; m_wv = 0; m_win = '0;
        end else begin
            occ = m_wr - m_rd;
            if (i_pixel_valid) begin
                if (occ < 4*LW) m_wr++;
                else if (m_drops < 65535) m_drops++;
            end
            m_wv   = m_reading;
            m_intr = 0;
            if (m_reading) begin
                m_win = exp_window((m_rd / LW) % 4, m_rd % LW);
                m_rd++;
                if (m_rd % LW == 0) begin
                    m_reading = 0;
                    m_intr    = 1;
                end
            end else if (occ >= 3*LW) begin
                m_reading = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit         chk_on = 0;
    logic [3:0] prev_rd_en = '0;
    logic [3:0] rd_en_seq[$];

    always @(negedge i_clk) begin
        bit         e_ready;
        logic [3:0] e_wv;
        logic [3:0] e_rd;
        if (chk_on) begin
            e_ready = (m_wr - m_rd) < 4*LW;
            e_wv    = (i_pixel_valid && e_ready) ? 4'(1 << ((m_wr / LW) % 4)) : 4'h0;
            // Reading touches every buffer except the one just behind the triple.
            e_rd    = m_reading ? (4'hF & ~4'(1 << (((m_rd / LW) + 3) % 4))) : 4'h0;
            chk("pixel_ready",  o_pixel_ready,  e_ready);
            chk("wr_valid",     o_wr_valid,     e_wv);
            chk("wr_data",      o_wr_data,      i_pixel_data);
            chk("rd_en",        o_rd_en,        e_rd);
            chk("window_valid", o_window_valid, m_wv);
            chk("window",       o_window,       m_win);
            chk("intr",         o_intr,         m_intr);
`ifdef LBC_DROP_CNT_EN
            chk("drop_cnt",     o_drop_cnt,     16'(m_drops));
`endif
            if (o_rd_en != 4'h0 && prev_rd_en == 4'h0) rd_en_seq.push_back(o_rd_en);
            prev_rd_en = o_rd_en;
        end
    end

    // ---------------- stimulus ----------------
    int pix_seq = 0;

    task automatic step(input bit v, input bit r);
        @(posedge i_clk);
        #1;
        i_buf_data    = gen_buf(m_rd % LW);
        i_pixel_valid = v;
        i_rst         = r;
        if (v) begin
            i_pixel_data = PW'(pix_seq);
            pix_seq++;
        end
        #1;
    endtask

    task automatic write_line_then_idle(input int idle_cycles);
        for (int c = 0; c < LW; c++) step(1'b1, 1'b0);
        for (int c = 0; c < idle_cycles; c++) step(1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0]     exp_seq[5];
        logic [4*SW-1:0] b0;
        bit             hit;

        b0 = gen_buf(0);
        i_buf_data = b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk_on = 1;

        chk("rst_ready",        o_pixel_ready,  1'b1);
        chk("rst_wr_valid",     o_wr_valid,     4'h0);
        chk("rst_rd_en",        o_rd_en,        4'h0);
        chk("rst_window",       o_window,       108'h0);
        chk("rst_window_valid", o_window_valid, 1'b0);
        chk("rst_intr",         o_intr,         1'b0);

        // 64 pixels back to back, then let two lines of windows drain.
        for (int c = 0; c < 90; c++) begin
            step(c < 64, 1'b0);
            if (c == 0)  chk("wv_line0", o_wr_valid, 4'b0001);
            if (c == 16) chk("wv_line1", o_wr_valid, 4'b0010);
            if (c == 32) chk("wv_line2", o_wr_valid, 4'b0100);
            if (c == 48) begin
                chk("wv_line3",     o_wr_valid, 4'b1000);
                chk("rd_idle_at48", o_rd_en,    4'b0000);
            end
            if (c == 49) chk("rd_first",  o_rd_en, 4'b0111);
            if (c == 50) begin
                chk("first_wvalid", o_window_valid, 1'b1);
                chk("first_window", o_window, 108'h000100200010110210020120220);
            end
            if (c == 64) chk("no_intr_yet", o_intr, 1'b0);
            if (c == 65) chk("intr_line1",  o_intr, 1'b1);
            if (c == 66) chk("rd_second",   o_rd_en, 4'b1110);
        end

        // Write pointer wraps back to buffer 0, then two more lines.
        step(1'b1, 1'b0);
        chk("wv_wrap", o_wr_valid, 4'b0001);
        for (int c = 1; c < LW; c++) step(1'b1, 1'b0);
        for (int c = 0; c < 30; c++) step(1'b0, 1'b0);
        write_line_then_idle(30);
        write_line_then_idle(30);

        exp_seq = '{4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        chk("rd_seq_len", 128'(rd_en_seq.size()), 128'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < rd_en_seq.size()) chk($sformatf("rd_seq[%0d]", i), rd_en_seq[i], exp_seq[i]);
        end

        // Reset in the middle of a READ line.
        for (int c = 0; c < LW; c++) step(1'b1, 1'b0);
        hit = 0;
        for (int c = 0; c < 60 && !hit; c++) begin
            step(1'b0, 1'b0);
            hit = m_reading && (m_rd % LW == 6);
        end
        chk("reached_rd6", hit, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("mid_rst_ready",        o_pixel_ready,  1'b1);
        chk("mid_rst_wr_valid",     o_wr_valid,     4'h0);
        chk("mid_rst_rd_en",        o_rd_en,        4'h0);
        chk("mid_rst_window",       o_window,       108'h0);
        chk("mid_rst_window_valid", o_window_valid, 1'b0);
        chk("mid_rst_intr",         o_intr,         1'b0);

        // Refill from buffer 0 and keep streaming until the bank is full.
        hit = 0;
        for (int c = 0; c < 1000 && !hit; c++) begin
            step(1'b1, 1'b0);
            if (c == 0)  chk("refill_wv", o_wr_valid, 4'b0001);
            if (c == 49) chk("refill_rd", o_rd_en,    4'b0111);
            hit = (m_wr - m_rd) == 4*LW;
        end
        chk("reached_full", hit, 1'b1);
        chk("full_ready",    o_pixel_ready, 1'b0);
        chk("full_wr_valid", o_wr_valid,    4'h0);
        step(1'b1, 1'b0);
        chk("after_full_ready", o_pixel_ready, 1'b1);
`ifdef LBC_DROP_CNT_EN
        chk("drop_cnt_one", o_drop_cnt, 16'd1);
`endif
        for (int c = 0; c < 40; c++) step(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
